// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter for the register file's single
// write port. It also keeps a busy scoreboard of the destination registers and
// a saturating count of stall cycles.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic [ADDR_WIDTH-1:0]      req0_addr,
  input  logic [DATA_WIDTH-1:0]      req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [ADDR_WIDTH-1:0]      req1_addr,
  input  logic [DATA_WIDTH-1:0]      req1_data,
  output logic                       req1_ready,
  input  logic                       rsv_valid,
  input  logic [ADDR_WIDTH-1:0]      rsv_addr,
  output logic                       rsv_ready,
  output logic [(1<<ADDR_WIDTH)-1:0] busy_mask,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [15:0]                stall_cnt
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  last_q, last_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [15:0]           stall_q, stall_d;

  logic                  xfer;
  logic [ADDR_WIDTH-1:0] xferAddr;
  logic [DATA_WIDTH-1:0] xferData;
  logic                  stallEvent;

  // Grant decision: a lone requester always wins; on contention the requester
  // that did not win last time goes first. Grants are suppressed while in reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst) begin
      req0_ready = req0_valid && (!req1_valid || last_q);
      req1_ready = req1_valid && (!req0_valid || !last_q);
    end
    xfer       = req0_ready || req1_ready;
    xferAddr   = req1_ready ? req1_addr : req0_addr;
    xferData   = req1_ready ? req1_data : req0_data;
    stallEvent = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);
  end

  // Reservation acceptance: r0 never becomes busy, so it is always accepted.
  always_comb begin
    rsv_ready = rst && rsv_valid && ((rsv_addr == '0) || !busy_q[rsv_addr]);
  end

  // Next-state for pointer, scoreboard and stall counter; the set is applied
  // after the clear so a same-edge set keeps the bit for the new producer.
  always_comb begin
    last_d  = last_q;
    busy_d  = busy_q;
    stall_d = stall_q;
    if (xfer) begin
      last_d           = req1_ready;
      busy_d[xferAddr] = 1'b0;
    end
    if (rsv_ready && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (stallEvent && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers and the registered write port to the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= 1'b1;
      busy_q  <= '0;
      stall_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      last_q  <= last_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
      wen_q   <= xfer && (xferAddr != '0);
      if (xfer) begin
        waddr_q <= xferAddr;
        wdata_q <= xferData;
      end
    end
  end

  assign busy_mask = busy_q;
  assign rf_wen    = wen_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign stall_cnt = stall_q;

endmodule
